// File: rtl/mmio_arbiter_if.sv
// Requester and driver-side signal bundle for the two-port MMIO arbiter.
interface mmio_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);

  // Requester 0 (host/test port)
  logic              r0_valid;
  logic              r0_cmd;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_lock;
  logic              r0_ready;
  logic [DATA_W-1:0] r0_rdata;
  logic              r0_err;

  // Requester 1 (program loader / ILA script engine)
  logic              r1_valid;
  logic              r1_cmd;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_lock;
  logic              r1_ready;
  logic [DATA_W-1:0] r1_rdata;
  logic              r1_err;

  // soc_driver user transaction port
  logic              drv_valid;
  logic              drv_cmd;
  logic [ADDR_W-1:0] drv_addr;
  logic [DATA_W-1:0] drv_wdata;
  logic              drv_ready;
  logic [DATA_W-1:0] drv_rdata;

  // Environment side: issues requests and plays the driver.
  modport master (
    output r0_valid, r0_cmd, r0_addr, r0_wdata, r0_lock,
    input  r0_ready, r0_rdata, r0_err,
    output r1_valid, r1_cmd, r1_addr, r1_wdata, r1_lock,
    input  r1_ready, r1_rdata, r1_err,
    input  drv_valid, drv_cmd, drv_addr, drv_wdata,
    output drv_ready, drv_rdata
  );

  // Arbiter side.
  modport slave (
    input  r0_valid, r0_cmd, r0_addr, r0_wdata, r0_lock,
    output r0_ready, r0_rdata, r0_err,
    input  r1_valid, r1_cmd, r1_addr, r1_wdata, r1_lock,
    output r1_ready, r1_rdata, r1_err,
    output drv_valid, drv_cmd, drv_addr, drv_wdata,
    input  drv_ready, drv_rdata
  );

endinterface

// File: rtl/mmio_arbiter.sv
// Two-requester round-robin arbiter and single-outstanding sequencer in front
// of the soc_driver user port, with bus lock and a per-transaction watchdog.
module mmio_arbiter #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 64,
  parameter int unsigned       TIMEOUT  = 2048,
  parameter logic [DATA_W-1:0] ERR_DATA = 64'hDEAD_DEAD_DEAD_DEAD
) (
  input  logic       clk,
  input  logic       rst_n,
  mmio_arbiter_if.slave bus,
  output logic       busy,
  output logic       owner,
  output logic [7:0] timeout_cnt
);

  localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic              cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              lock;
  } req_t;

  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              lock_hold_q, lock_hold_d;
  logic              owner_q, owner_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [7:0]        tcnt_q, tcnt_d;
  logic              busy_q, busy_d;
  logic              drv_valid_q, drv_valid_d;
  logic              r0_ready_q, r0_ready_d;
  logic              r1_ready_q, r1_ready_d;
  logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
  logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;
  logic              r0_err_q, r0_err_d;
  logic              r1_err_q, r1_err_d;

  logic              grant_vld;
  logic              grant_id;
  logic              lock_live;
  logic [DATA_W-1:0] done_data;
  logic              done_err;

  // State and registered outputs; async reset aborts any transaction silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      rr_ptr_q    <= 1'b0;
      lock_hold_q <= 1'b0;
      owner_q     <= 1'b0;
      wd_q        <= '0;
      tcnt_q      <= '0;
      busy_q      <= 1'b0;
      drv_valid_q <= 1'b0;
      r0_ready_q  <= 1'b0;
      r1_ready_q  <= 1'b0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
      r0_err_q    <= 1'b0;
      r1_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_hold_q <= lock_hold_d;
      owner_q     <= owner_d;
      wd_q        <= wd_d;
      tcnt_q      <= tcnt_d;
      busy_q      <= busy_d;
      drv_valid_q <= drv_valid_d;
      r0_ready_q  <= r0_ready_d;
      r1_ready_q  <= r1_ready_d;
      r0_rdata_q  <= r0_rdata_d;
      r1_rdata_q  <= r1_rdata_d;
      r0_err_q    <= r0_err_d;
      r1_err_q    <= r1_err_d;
    end
  end

  // Next-state: arbitration in IDLE, issue, watchdog wait, completion routing.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rr_ptr_d    = rr_ptr_q;
    lock_hold_d = lock_hold_q;
    owner_d     = owner_q;
    wd_d        = wd_q;
    tcnt_d      = tcnt_q;
    drv_valid_d = 1'b0;
    r0_ready_d  = 1'b0;
    r1_ready_d  = 1'b0;
    r0_rdata_d  = r0_rdata_q;
    r1_rdata_d  = r1_rdata_q;
    r0_err_d    = r0_err_q;
    r1_err_d    = r1_err_q;
    grant_vld   = 1'b0;
    grant_id    = 1'b0;
    lock_live   = 1'b0;
    done_data   = '0;
    done_err    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A lock only survives while its owner keeps requesting.
        lock_live = lock_hold_q && (owner_q ? bus.r1_valid : bus.r0_valid);
        if (lock_hold_q && !lock_live) begin
          lock_hold_d = 1'b0;
        end
        if (lock_live) begin
          grant_vld = 1'b1;
          grant_id  = owner_q;
        end else if (bus.r0_valid && bus.r1_valid) begin
          grant_vld = 1'b1;
          grant_id  = rr_ptr_q;
        end else if (bus.r0_valid) begin
          grant_vld = 1'b1;
          grant_id  = 1'b0;
        end else if (bus.r1_valid) begin
          grant_vld = 1'b1;
          grant_id  = 1'b1;
        end
        if (grant_vld) begin
          owner_d     = grant_id;
          req_d.cmd   = grant_id ? bus.r1_cmd   : bus.r0_cmd;
          req_d.addr  = grant_id ? bus.r1_addr  : bus.r0_addr;
          req_d.wdata = grant_id ? bus.r1_wdata : bus.r0_wdata;
          req_d.lock  = grant_id ? bus.r1_lock  : bus.r0_lock;
          drv_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        wd_d = wd_q + WD_W'(1);
        // Driver completion beats a watchdog expiry in the same cycle.
        if (bus.drv_ready || (wd_q == WD_W'(TIMEOUT - 1))) begin
          done_data = bus.drv_ready ? bus.drv_rdata : ERR_DATA;
          done_err  = !bus.drv_ready;
          if (!bus.drv_ready && (tcnt_q != 8'hFF)) begin
            tcnt_d = tcnt_q + 8'd1;
          end
          if (owner_q) begin
            r1_ready_d = 1'b1;
            r1_rdata_d = done_data;
            r1_err_d   = done_err;
          end else begin
            r0_ready_d = 1'b1;
            r0_rdata_d = done_data;
            r0_err_d   = done_err;
          end
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        rr_ptr_d    = ~owner_q;
        lock_hold_d = req_q.lock;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Output wiring from registers.
  assign bus.drv_valid = drv_valid_q;
  assign bus.drv_cmd   = req_q.cmd;
  assign bus.drv_addr  = req_q.addr;
  assign bus.drv_wdata = req_q.wdata;
  assign bus.r0_ready  = r0_ready_q;
  assign bus.r0_rdata  = r0_rdata_q;
  assign bus.r0_err    = r0_err_q;
  assign bus.r1_ready  = r1_ready_q;
  assign bus.r1_rdata  = r1_rdata_q;
  assign bus.r1_err    = r1_err_q;
  assign busy          = busy_q;
  assign owner         = owner_q;
  assign timeout_cnt   = tcnt_q;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter: per-transaction vector table plus
// contention, lock burst, stray driver ready and mid-WAIT reset sequences.
module tb_mmio_arbiter;

  localparam int unsigned TB_TIMEOUT = 16;
  localparam logic [63:0] ERR        = 64'hDEAD_DEAD_DEAD_DEAD;

  typedef struct {
    bit          id;
    bit          cmd;
    logic [31:0] addr;
    logic [63:0] wdata;
    bit          lock;
    int          delay;     // WAIT cycle on which drv_ready lands; 0 = never
    logic [63:0] drv_data;
    logic [63:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;   // negedges from ISSUE to DONE
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic       owner;
  logic [7:0] timeout_cnt;
  logic       resp_ready;
  logic       stray_ready;

  mmio_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  assign bus.drv_ready = resp_ready | stray_ready;

  mmio_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (64),
    .TIMEOUT (TB_TIMEOUT),
    .ERR_DATA(ERR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .owner      (owner),
    .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          r0_cnt = 0;
  int          r1_cnt = 0;
  int          tcnt_exp = 0;
  bit          resp_en = 1'b0;
  int          resp_delay = 1;
  logic [63:0] resp_data = '0;
  logic        owner_log[$];
  logic [31:0] addr_log[$];
  vec_t        vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input bit id);
    return id ? bus.r1_ready : bus.r0_ready;
  endfunction

  function automatic logic [63:0] rdat(input bit id);
    return id ? bus.r1_rdata : bus.r0_rdata;
  endfunction

  function automatic logic rerr(input bit id);
    return id ? bus.r1_err : bus.r0_err;
  endfunction

  task automatic set_req(input bit id, input bit v, input bit cmd, input logic [31:0] a,
                         input logic [63:0] w, input bit lk);
    if (id) begin
      bus.r1_valid = v; bus.r1_cmd = cmd; bus.r1_addr = a; bus.r1_wdata = w; bus.r1_lock = lk;
    end else begin
      bus.r0_valid = v; bus.r0_cmd = cmd; bus.r0_addr = a; bus.r0_wdata = w; bus.r0_lock = lk;
    end
  endtask

  // Driver model: answers each issue pulse after resp_delay WAIT cycles.
  initial begin
    resp_ready    = 1'b0;
    bus.drv_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.drv_valid && resp_en) begin
        int          d;
        logic [63:0] data;
        d    = resp_delay;
        data = resp_data;
        repeat (d) @(negedge clk);
        resp_ready    = 1'b1;
        bus.drv_rdata = data;
        @(negedge clk);
        resp_ready = 1'b0;
      end
    end
  end

  // Observer: logs issue order and counts completion pulses per port.
  always @(posedge clk) begin
    #1;
    if (bus.drv_valid) begin
      owner_log.push_back(owner);
      addr_log.push_back(bus.drv_addr);
    end
    if (bus.r0_ready) r0_cnt++;
    if (bus.r1_ready) r1_cnt++;
  end

  // One complete transaction from a single requester, starting in IDLE.
  task automatic run_row(input string tag, input vec_t v);
    int          c;
    int          lat;
    int          oth_cnt;
    logic [63:0] oth_rdata;
    logic        oth_err;
    @(negedge clk);
    resp_en    = (v.delay != 0);
    resp_delay = v.delay;
    resp_data  = v.drv_data;
    oth_cnt    = v.id ? r0_cnt : r1_cnt;
    oth_rdata  = rdat(!v.id);
    oth_err    = rerr(!v.id);
    set_req(v.id, 1'b1, v.cmd, v.addr, v.wdata, v.lock);
    c = 0;
    do begin @(negedge clk); c++; end while (!bus.drv_valid && c < 8);
    check({tag, "_grant_lat"}, 64'(c), 64'd1);
    check({tag, "_drv_cmd"}, 64'(bus.drv_cmd), 64'(v.cmd));
    check({tag, "_drv_addr"}, 64'(bus.drv_addr), 64'(v.addr));
    check({tag, "_drv_wdata"}, bus.drv_wdata, v.wdata);
    check({tag, "_owner"}, 64'(owner), 64'(v.id));
    // Inputs changing after grant must not reach the driver.
    set_req(v.id, 1'b1, ~v.cmd, ~v.addr, ~v.wdata, v.lock);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rdy(v.id) && lat < 40);
    if (v.exp_err) tcnt_exp++;
    check({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
    check({tag, "_ready"}, 64'(rdy(v.id)), 64'd1);
    check({tag, "_rdata"}, rdat(v.id), v.exp_rdata);
    check({tag, "_err"}, 64'(rerr(v.id)), 64'(v.exp_err));
    check({tag, "_timeout_cnt"}, 64'(timeout_cnt), 64'(tcnt_exp));
    check({tag, "_latched_addr"}, 64'(bus.drv_addr), 64'(v.addr));
    check({tag, "_latched_cmd"}, 64'(bus.drv_cmd), 64'(v.cmd));
    check({tag, "_other_ready_cnt"}, 64'(v.id ? r0_cnt : r1_cnt), 64'(oth_cnt));
    check({tag, "_other_rdata"}, rdat(!v.id), oth_rdata);
    check({tag, "_other_err"}, 64'(rerr(!v.id)), 64'(oth_err));
    set_req(v.id, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
  endtask

  // Requester issuing n back-to-back transactions by holding valid high.
  task automatic agent(input bit id, input int n, input logic [31:0] base, input bit cmd,
                       input bit lk);
    int w;
    for (int k = 0; k < n; k++) begin
      set_req(id, 1'b1, cmd, base + 32'(4 * k), 64'(k), lk && (k < n - 1));
      w = 0;
      do begin @(negedge clk); w++; end while (!rdy(id) && w < 100);
      check($sformatf("agent%0d_txn%0d_ready", id, k), 64'(rdy(id)), 64'd1);
    end
    set_req(id, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic        exp_own[6];
    logic [31:0] exp_adr[6];
    vec_t        rv;
    int          c;
    int          c0;
    int          c1;

    //            id    cmd   addr      wdata                   lock  dly drv_data        exp_rdata       err   lat
    vecs[0] = '{1'b0, 1'b0, 32'h10, 64'h0,                  1'b0, 3,  64'h1234,       64'h1234,       1'b0, 4};
    vecs[1] = '{1'b1, 1'b1, 32'h20, 64'hA5A5_0000_0000_5A5A, 1'b1, 1,  64'h55,         64'h55,         1'b0, 2};
    vecs[2] = '{1'b0, 1'b0, 32'h30, 64'h0,                  1'b0, 0,  64'h0,          ERR,            1'b1, 17};
    vecs[3] = '{1'b1, 1'b0, 32'h40, 64'h0,                  1'b0, 16, 64'h7777,       64'h7777,       1'b0, 17};
    vecs[4] = '{1'b1, 1'b1, 32'h44, 64'h1,                  1'b0, 0,  64'h0,          ERR,            1'b1, 17};
    vecs[5] = '{1'b0, 1'b1, 32'h50, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5,  64'h0,          64'h0,          1'b0, 6};

    stray_ready = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_owner", 64'(owner), 64'd0);
    check("rst_timeout_cnt", 64'(timeout_cnt), 64'd0);
    check("rst_drv_valid", 64'(bus.drv_valid), 64'd0);
    check("rst_drv_addr", 64'(bus.drv_addr), 64'd0);
    check("rst_drv_wdata", bus.drv_wdata, 64'd0);
    check("rst_r0_ready", 64'(bus.r0_ready), 64'd0);
    check("rst_r1_ready", 64'(bus.r1_ready), 64'd0);
    check("rst_r0_rdata", bus.r0_rdata, 64'd0);
    check("rst_r1_err", 64'(bus.r1_err), 64'd0);
    rst_n = 1'b1;

    // Vector table: one transaction per row.
    for (int i = 0; i < 6; i++) begin
      run_row($sformatf("row%0d", i), vecs[i]);
    end

    // drv_ready outside WAIT is ignored.
    @(negedge clk);
    c0 = r0_cnt; c1 = r1_cnt; c = addr_log.size();
    stray_ready = 1'b1;
    @(negedge clk);
    stray_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stray_busy%0d", i), 64'(busy), 64'd0);
    end
    check("stray_ready_cnt", 64'(r0_cnt + r1_cnt), 64'(c0 + c1));
    check("stray_issue_cnt", 64'(addr_log.size()), 64'(c));

    // Reset in the middle of WAIT.
    resp_en = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 32'h60, 64'h0, 1'b0);
    c = 0;
    do begin @(negedge clk); c++; end while (!bus.drv_valid && c < 8);
    check("midrst_issue", 64'(bus.drv_valid), 64'd1);
    repeat (3) @(negedge clk);
    check("midrst_busy_before", 64'(busy), 64'd1);
    c0 = r0_cnt;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_drv_addr", 64'(bus.drv_addr), 64'd0);
    check("midrst_r0_ready", 64'(bus.r0_ready), 64'd0);
    check("midrst_timeout_cnt", 64'(timeout_cnt), 64'd0);
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tcnt_exp = 0;
    rv = '{1'b1, 1'b0, 32'h70, 64'h0, 1'b0, 2, 64'hBEEF, 64'hBEEF, 1'b0, 3};
    run_row("post_rst", rv);
    check("midrst_no_r0_ready", 64'(r0_cnt), 64'(c0));

    // Contention from reset: strict alternation, r0 first.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tcnt_exp = 0;
    resp_en = 1'b1; resp_delay = 2; resp_data = 64'h0;
    owner_log.delete(); addr_log.delete();
    fork
      agent(1'b0, 3, 32'h100, 1'b0, 1'b0);
      agent(1'b1, 3, 32'h200, 1'b0, 1'b0);
    join
    exp_own = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_adr = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208};
    check("cont_issue_cnt", 64'(owner_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("cont_owner%0d", i), 64'((i < owner_log.size()) ? owner_log[i] : 1'bx),
            64'(exp_own[i]));
      check($sformatf("cont_addr%0d", i), 64'((i < addr_log.size()) ? addr_log[i] : 32'hx),
            64'(exp_adr[i]));
    end

    // Lock burst: r1 holds the bus for three writes while r0 waits.
    @(negedge clk);
    owner_log.delete(); addr_log.delete();
    fork
      agent(1'b1, 3, 32'h0, 1'b1, 1'b1);
      begin
        repeat (2) @(negedge clk);
        agent(1'b0, 1, 32'h300, 1'b0, 1'b0);
      end
    join
    exp_own[0:3] = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp_adr[0:3] = '{32'h0, 32'h4, 32'h8, 32'h300};
    check("lock_issue_cnt", 64'(owner_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lock_owner%0d", i), 64'((i < owner_log.size()) ? owner_log[i] : 1'bx),
            64'(exp_own[i]));
      check($sformatf("lock_addr%0d", i), 64'((i < addr_log.size()) ? addr_log[i] : 32'hx),
            64'(exp_adr[i]));
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_arbiter.md
Name: mmio_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the soc_driver user transaction port.
- Requester 0 is the host/test port. Requester 1 is the on-chip program loader/ILA script engine.
- Grants the single driver port round-robin, with optional bus lock for multi-word bursts.
- Latches and issues one transaction at a time, routes the completion back to the owning requester, and guards each transaction with a watchdog.

Parameters:
- ADDR_W, 32, MMIO address width (matches driver user_addr).
- DATA_W, 64, MMIO data width (matches driver user_wdata/user_rdata).
- TIMEOUT, 2048, maximum cycles spent in WAIT before forced error completion.
- ERR_DATA, 64'hDEAD_DEAD_DEAD_DEAD, rdata returned on timeout.

Ports:
- clk  in  1  system clock (ungated domain, same as soc_driver).
- rst_n  in  1  asynchronous, active-low reset.
- r0_valid  in  1  requester 0 request, level; held until r0_ready.
- r0_cmd  in  1  0=read, 1=write.
- r0_addr  in  ADDR_W  address.
- r0_wdata  in  DATA_W  write data.
- r0_lock  in  1  keep grant after this transaction.
- r0_ready  out  1  one-cycle completion pulse.
- r0_rdata  out  DATA_W  read data, valid with r0_ready.
- r0_err  out  1  timeout flag, valid with r0_ready.
- r1_valid, r1_cmd, r1_addr, r1_wdata, r1_lock, r1_ready, r1_rdata, r1_err: same as the r0_* ports, for requester 1.
- drv_valid  out  1  one-cycle issue pulse to driver user_valid.
- drv_cmd  out  1  latched cmd.
- drv_addr  out  ADDR_W  latched addr.
- drv_wdata  out  DATA_W  latched wdata.
- drv_ready  in  1  driver completion pulse.
- drv_rdata  in  DATA_W  driver read data.
- busy  out  1  state != IDLE.
- owner  out  1  id of current/last granted requester.
- timeout_cnt  out  8  saturating count of timeouts.

Behaviour:
- Reset values:
  - All outputs 0, including drv_* and r*_rdata.
  - State IDLE, rr_ptr=0 (requester 0 has priority first), lock_hold=0.
- State IDLE:
  - Candidate set: {r0_valid, r1_valid}.
  - If lock_hold=1, only the locked owner may be granted; the other requester waits regardless of its valid.
  - If lock_hold=0 and both are valid, grant the requester matching rr_ptr.
  - If lock_hold=0 and one is valid, grant it.
  - On grant: latch cmd/addr/wdata/lock of the winner, set owner, go to ISSUE. Fixed 1-cycle grant latency.
- State ISSUE:
  - drv_valid=1 for exactly this cycle with latched fields; go to WAIT.
  - Clear the watchdog counter.
  - drv_cmd/addr/wdata stay stable until the next grant.
- State WAIT:
  - Count cycles.
  - On drv_ready: capture drv_rdata, go to DONE with err=0.
  - If the count reaches TIMEOUT-1 without drv_ready: capture ERR_DATA, err=1, increment timeout_cnt (saturate at 255), go to DONE.
  - If drv_ready and timeout coincide, drv_ready wins (err=0).
- State DONE:
  - Pulse ready/rdata/err on the owner's port only, for exactly 1 cycle.
  - Set rr_ptr = ~owner.
  - Set lock_hold = latched lock.
  - Go to IDLE.
- The other requester's ready never pulses. Its rdata/err keep their last values.
- A requester still asserting valid in the IDLE cycle after its ready pulse is a new transaction.
- Minimum transaction period: 4 cycles (IDLE, ISSUE, WAIT≥1, DONE).
- Lock release:
  - lock_hold clears at DONE of a transaction whose latched lock=0.
  - lock_hold also clears in IDLE if the locked owner's valid is low. The grant decision in that same cycle uses lock_hold=0.
- A drv_ready pulse outside WAIT is ignored.
- Requester input changes after grant are ignored (latched).
- Asynchronous reset mid-transaction: immediately return to IDLE and clear outputs. No ready pulse for the aborted transaction. The driver is reset by the same rst_n.

Test Plan:
- Single read: r0 read addr 0x10, driver returns ready 3 cycles after drv_valid with 0x1234 -> one drv_valid pulse with addr 0x10, cmd 0; r0_ready pulses 1 cycle with r0_rdata=0x1234, r0_err=0; r1_ready stays 0.
- Contention: r0 and r1 both valid from reset, each issues 3 transactions -> driver order r0,r1,r0,r1,r0,r1; owner toggles accordingly.
- Lock burst: r1 asserts lock on writes to 0x0,0x4,0x8 (lock low on last), r0 valid throughout -> three r1 transactions back-to-back, then r0 is granted.
- Timeout: with TIMEOUT=16, drv_ready never comes -> r0_ready at cycle 16 of WAIT with r0_rdata=ERR_DATA, r0_err=1, timeout_cnt=1; next request proceeds normally.
- Coincident ready/timeout: drv_ready lands on the final WAIT cycle -> err=0, rdata = drv_rdata, timeout_cnt unchanged.
- Reset mid-WAIT: assert rst_n low during WAIT -> busy=0, no r*_ready pulse; after release, a fresh r1 request is granted first (rr_ptr=0 and r0 idle).
